div_sequencer: RTL and testbench

Multi-cycle controller and iterative datapath for MIPS DIV/DIVU, sitting beside the EX-stage ALU. It accepts one division request from the pipeline and runs a radix-2 restoring divide over WIDTH cycles. While running it holds the pipeline stalled, then presents {remainder, quotient} for the HI/LO write. A pipeline flush (annul) aborts it at any point.

---
 rtl/div_sequencer_pkg.sv | 17 +
 rtl/div_step.sv | 28 ++
 rtl/div_sequencer.sv | 129 ++++++++++++
 tb/tb_div_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared divider state encodings, iteration count and EX-stage funct codes
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ON   = 2'd1,
        DIV_END  = 2'd2
    } div_state_e;

    // Iteration count of the radix-2 divider, one quotient bit per cycle.
    localparam int DIV_CYCLES = 32;

    // SPECIAL-opcode funct fields the EX stage decodes into start/signed_div.
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational shift/trial-subtract iteration of a restoring divide
// acc      in  {partial remainder, remaining dividend bits}
// divisor  in  divisor magnitude
// acc_next out shifted {remainder, dividend} with the new quotient bit in the LSB
module div_step
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           qbit;

    always_comb begin
        // Keep the bit shifted out of the remainder: the shifted value can reach
        // 2*divisor-1, which needs WIDTH+1 bits before the subtract.
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, divisor};
        qbit     = ~diff[WIDTH];
        acc_next = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], qbit};
    end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle DIV/DIVU controller with iterative restoring datapath
// clk, rst            clock, synchronous active-high reset
// start, signed_div   division request and DIV(1)/DIVU(0) select, sampled in IDLE
// opdata1, opdata2    dividend and divisor, sampled with start
// annul               pipeline flush, aborts to IDLE
// result              {remainder, quotient}, registered, held until next completion
// ready               one-cycle completion pulse, registered
// stall               combinational pipeline stall request
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e         state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic               q_neg, r_neg;
    logic               last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .divisor  (divisor),
        .acc_next (acc_next)
    );

    always_comb begin
        // The most negative value maps onto itself, which is the correct
        // unsigned magnitude, so no special case is needed.
        op1_mag = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        op2_mag = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
        last    = (cnt == CW'(WIDTH - 1));
        q_fix   = q_neg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        r_fix   = r_neg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    end

    assign stall = (state == DIV_ON) || (state == DIV_IDLE && start && !annul && !rst);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: begin
                if (start) begin
                    state_next = (opdata2 == '0) ? DIV_END : DIV_ON;
                end
            end
            DIV_ON: begin
                if (last) begin
                    state_next = DIV_END;
                end
            end
            DIV_END: state_next = DIV_IDLE;
            default: state_next = DIV_IDLE;
        endcase
        if (annul) begin
            state_next = DIV_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            ready   <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            divisor <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            ready <= (state_next == DIV_END);
            if (annul) begin
                cnt     <= '0;
                acc     <= '0;
                divisor <= '0;
                q_neg   <= 1'b0;
                r_neg   <= 1'b0;
            end else begin
                case (state)
                    DIV_IDLE: begin
                        if (start) begin
                            if (opdata2 != '0) begin
                                acc     <= {{WIDTH{1'b0}}, op1_mag};
                                divisor <= op2_mag;
                                q_neg   <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                                r_neg   <= signed_div && opdata1[WIDTH-1];
                                cnt     <= '0;
                            end else begin
                                result <= '0;
                            end
                        end
                    end
                    DIV_ON: begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            result <= {r_fix, q_fix};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer
module tb_div_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          signed_div;
    logic [W-1:0]  opdata1;
    logic [W-1:0]  opdata2;
    logic          annul;
    logic [2*W-1:0] result;
    logic          ready;
    logic          stall;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t tbl[9];

    div_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: language-level division, truncating toward zero, reduced mod 2^32.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_div(input string name, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int lat;
        int want_lat;
        logic stall_bad;
        lat = 0;
        stall_bad = 1'b0;
        want_lat = (b == 0) ? 1 : W + 1;
        @(negedge clk);
        start = 1'b1; signed_div = sd; opdata1 = a; opdata2 = b;
        #1;
        check({name, " stall_n"}, {63'd0, stall}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= W + 10; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            if (stall !== ((b != 0) && (i <= W))) stall_bad = 1'b1;
            if (ready === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({name, " stall_window"}, {63'd0, stall_bad}, 64'd0);
        check({name, " latency"}, 64'(lat), 64'(want_lat));
        check({name, " result"}, result, exp);
        @(negedge clk);
        #1;
        check({name, " ready_pulse"}, {63'd0, ready}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] prev;
        logic        saw_ready;
        logic        sd;
        logic [31:0] a, b;

        tbl[0] = '{1'b0, 32'd100,        32'd7,        32'h0000000E, 32'h00000002};
        tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
        tbl[2] = '{1'b0, 32'hFFFFFFF9,   32'h00000002, 32'h7FFFFFFC, 32'h00000001};
        tbl[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        tbl[4] = '{1'b0, 32'd123,        32'd0,        32'h00000000, 32'h00000000};
        tbl[5] = '{1'b1, 32'h00000007,   32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
        tbl[6] = '{1'b0, 32'hFFFFFFFF,   32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        tbl[7] = '{1'b0, 32'h00000005,   32'hFFFFFFFF, 32'h00000000, 32'h00000005};
        tbl[8] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; annul = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; opdata2 = 32'd3;
        #1;
        check("reset stall", {63'd0, stall}, 64'd0);
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk);
        start = 1'b0; rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_div($sformatf("vec%0d", i), tbl[i].sd, tbl[i].a, tbl[i].b, {tbl[i].r, tbl[i].q});
        end

        for (int i = 0; i < 16; i++) begin
            sd = 1'($urandom);
            a  = $urandom;
            case (i % 4)
                0: b = $urandom_range(1, 15);
                1: b = $urandom;
                2: b = -$urandom_range(1, 15);
                default: b = a >> $urandom_range(0, 31);
            endcase
            do_div($sformatf("rand%0d", i), sd, a, b, model(sd, a, b));
        end

        // Annul in cycle N+10 of a running divide.
        do_div("pre_annul", 1'b0, 32'd1000, 32'd9, {32'd1, 32'd111});
        prev = result;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd500; opdata2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        #1;
        check("annul stall_m", {63'd0, stall}, 64'd1);
        @(negedge clk);
        annul = 1'b0;
        #1;
        check("annul stall_m1", {63'd0, stall}, 64'd0);
        saw_ready = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            #1;
            if (ready === 1'b1 || stall === 1'b1) saw_ready = 1'b1;
        end
        check("annul quiet", {63'd0, saw_ready}, 64'd0);
        check("annul result_kept", result, prev);
        do_div("post_annul", 1'b1, 32'hFFFFFF9C, 32'd7, model(1'b1, 32'hFFFFFF9C, 32'd7));

        // rst at N+5 of a running divide.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd77; opdata2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst ready", {63'd0, ready}, 64'd0);
        check("rst stall", {63'd0, stall}, 64'd0);
        check("rst result", result, 64'd0);
        @(negedge clk);
        start = 1'b1; annul = 1'b1; opdata2 = 32'd5;
        #1;
        check("annul_start stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        check("annul_start idle", {62'd0, stall, ready}, 64'd0);
        do_div("post_rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
